tag_merge: RTL
==============

# tag_merge

Tagged-stream merger: collects up to FLUX independent untagged producer streams and serialises them onto one tagged output stream, prefixing each token with the index of its source channel. This is the transmit-side counterpart of the PICK actor. The merger's output feeds a FIFO whose tagged tokens PICK later steers back to FLUX consumers. It uses the codebase's write/full dataflow handshake on every port.

## Interface
- FLUX, 2: number of input channels; legal range FLUX ≥ 2.
- DATA_WIDTH, 8: payload width per token.
- TAG_WIDTH, $clog2(FLUX): tag width.
- WIDTH, DATA_WIDTH+TAG_WIDTH: output token width.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- in_port_write  in  FLUX  per-channel write strobe; bit i belongs to channel i.
- in_port_datain  in  FLUX*DATA_WIDTH  channel i payload at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_port_full  out  FLUX  per-channel full; bit i high means channel i holding register is occupied.
- out_port_write  out  1  one-cycle pulse per emitted token.
- out_port_dataout  out  WIDTH  layout {tag[TAG_WIDTH-1:0], payload[DATA_WIDTH-1:0]}, tag in the MSBs.
- out_port_full  in  1  downstream FIFO full.

## Operation
- **Holding registers.** Each channel i has a one-entry holding register with a valid bit. in_port_full[i] equals valid[i] and is registered.
- **Accepting writes.** A write on channel i is accepted at a rising edge when in_port_write[i]=1 and valid[i]=0. The payload is captured and valid[i] is set.
- **Writes while full.** A write while valid[i]=1 is ignored. The held token and its payload stay unchanged, and no error is flagged.
- **Arbitration.** Round-robin grant pointer `last`, range 0..FLUX-1, reset value FLUX-1, so channel 0 has first priority after reset.
  - Each cycle with out_port_full=0 and at least one valid holder, grant the first valid channel searching from last+1 upward, modulo FLUX.
  - On a grant to channel g: last←g, valid[g]←0, out_port_write←1, out_port_dataout←{g[TAG_WIDTH-1:0], hold[g]}.
  - With no grant: out_port_write←0, and out_port_dataout holds its previous value.
- **Back-pressure.** out_port_full=1 suppresses granting entirely. The pointer and holders stay frozen, and accepted writes to empty holders still proceed.
- **Grant and write on the same channel.** A channel granted in cycle k shows in_port_full[g]=0 after edge k. A new write to that channel is accepted only at edge k+1 or later. Consequently, per-channel throughput is at most 1 token per 2 cycles; aggregate output throughput is 1 token per cycle while ≥2 channels are loaded.
- **Ordering.** Tokens from the same channel leave in arrival order. Inter-channel order is set by the round-robin rule only.
- **Reset** (rst=0, asynchronous, effective immediately):
  - out_port_write=0, out_port_dataout=0, in_port_full=0.
  - All valid bits cleared; last=FLUX-1.
  - Tokens held at reset, mid-operation included, are discarded. Normal operation resumes on the first rising edge after rst returns high.

## Timing
- **Latency, write to output.** A write accepted at edge k makes valid/in_port_full high after edge k. If granted at edge k+1, out_port_write and out_port_dataout are valid after edge k+1. Minimum latency is 2 edges.
- **Grant decision inputs.** The decision at edge k uses only registered state (valid, last) and the current out_port_full. There is no combinational path from in_port_write or in_port_datain to any output.
- **Output pulse.** out_port_write is high for exactly one cycle per token and is never high while the token's grant cycle saw out_port_full=1.
- **Full deassertion.** in_port_full[g] falls in the same cycle out_port_write rises for that token.
- **Tag width.** The tag is the grant index truncated to TAG_WIDTH bits. When FLUX is not a power of two, tag values ≥ FLUX are never produced.

## Test plan
- **Reset values.** Hold rst=0 mid-stream with channels 0 and 1 valid → immediately out_port_write=0, out_port_dataout=0, in_port_full=2'b00. After release, the first write on ch1 (0x5A) emits tagged 0x15A and no stale token.
- **Single channel.** FLUX=2, DATA_WIDTH=8, write 0xA5 on ch0 at edge 0 → in_port_full=2'b01 after edge 0; out_port_write pulse after edge 1 with dataout 0x0A5; in_port_full=2'b00.
- **Round robin.** Ch0 writes 0x11 and ch1 writes 0x22 on the same edge, then both refill as soon as full drops, for 6 tokens → output sequence 0x011, 0x122, 0x011, 0x122, …; gapless pulses once both are loaded.
- **Back-pressure.** Load ch0=0x33 and ch1=0x44, hold out_port_full=1 for 5 cycles → no out_port_write and in_port_full=2'b11. Writes during this window are ignored and the held payloads stay 0x33 and 0x44. On release, 0x033 is emitted and then 0x144 on consecutive cycles.
- **FLUX=3 wrap.** Channels 0, 1 and 2 are loaded continuously → tags 0, 1, 2, 0, 1, 2; the tag field never equals 3.
- **Write while full.** Ch1 holds 0x77, and 0x99 is written while in_port_full[1]=1 → emitted token is 0x177 and 0x99 is never emitted.

Source files
------------

// File: rtl/tag_merge.sv
// ---------------------------------------------------------------------------
// tag_merge
//
// Serialises FLUX independent untagged producer streams onto one tagged
// output stream. Each emitted token is prefixed with the index of the
// channel it came from, so a downstream PICK can steer it back to the
// matching consumer. Every port uses the write/full dataflow handshake.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous, active-low reset
//   in_port_write     per-channel write strobe (bit i = channel i)
//   in_port_datain    channel i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_port_full      per-channel holding-register occupied flag (registered)
//   out_port_write    one-cycle pulse per emitted token
//   out_port_dataout  {tag, payload}, tag in the MSBs
//   out_port_full     downstream FIFO full; suppresses granting
// ---------------------------------------------------------------------------
module tag_merge #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = $clog2(FLUX),
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLUX-1:0]            in_port_write,
  input  logic [FLUX*DATA_WIDTH-1:0] in_port_datain,
  output logic [FLUX-1:0]            in_port_full,
  output logic                       out_port_write,
  output logic [WIDTH-1:0]           out_port_dataout,
  input  logic                       out_port_full
);

  // One-entry holding register per channel.
  logic [FLUX-1:0]       valid_q, valid_d;
  logic [DATA_WIDTH-1:0] hold_q [FLUX];

  // Round-robin pointer: index of the most recently granted channel.
  logic [TAG_WIDTH-1:0]  last_q, last_d;

  // Registered output stage; no input-to-output combinational path.
  logic                  out_write_q, out_write_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;

  // Arbitration results for the current cycle.
  logic                  grant_vld;
  logic [TAG_WIDTH-1:0]  grant_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [FLUX-1:0]       grant_mask;
  logic [TAG_WIDTH-1:0]  cand;
  logic [FLUX-1:0]       accept;

  // -------------------------------------------------------------------------
  // Arbiter: first valid channel searching upward from last+1, modulo FLUX.
  // The decision uses only registered state plus out_port_full.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment;
    // otherwise paths that skip an assignment infer a latch.
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    grant_mask = '0;
    cand       = '0;
    for (int i = 1; i <= FLUX; i++) begin
      cand = TAG_WIDTH'((int'(last_q) + i) % FLUX);
      if (!out_port_full && !grant_vld && valid_q[cand]) begin
        grant_vld        = 1'b1;
        grant_idx        = cand;
        grant_data       = hold_q[cand];
        grant_mask[cand] = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. A channel is only granted while valid and only accepts
  // a write while empty, so grant and accept never hit the same channel in
  // one cycle; a refill after a grant lands one edge later.
  // -------------------------------------------------------------------------
  always_comb begin
    accept      = in_port_write & ~valid_q;
    valid_d     = (valid_q | accept) & ~grant_mask;
    last_d      = grant_vld ? grant_idx : last_q;
    out_write_d = grant_vld;
    // Output data holds its last value when nothing is granted.
    out_data_d  = grant_vld ? {grant_idx, grant_data} : out_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      last_q      <= TAG_WIDTH'(FLUX - 1);
      out_write_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      last_q      <= last_d;
      out_write_q <= out_write_d;
      out_data_q  <= out_data_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; its contents are only
  // observable through a set valid bit, and valid is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FLUX; i++) begin
      if (accept[i]) begin
        hold_q[i] <= in_port_datain[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_port_full     = valid_q;
  assign out_port_write   = out_write_q;
  assign out_port_dataout = out_data_q;

endmodule
